// File: rtl/slc3_pkg.sv
// Shared types and encodings for the SLC-3 control sequencer.
// States, opcodes, mux/ALU select codes and the default memory latency.
package slc3_pkg;

  localparam int MEM_WAIT_DEF = 2;

  typedef enum logic [4:0] {
    HALTED,
    S18,
    S33,
    S35,
    S32,
    S1,
    S5,
    S9,
    S0,
    S22,
    S12,
    S4,
    S21,
    S6,
    S25,
    S27,
    S7,
    S23,
    S16,
    PAUSE1,
    PAUSE2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  function automatic logic is_wait(input state_t s);
    return (s == S33) || (s == S25) || (s == S16);
  endfunction

endpackage

// File: rtl/slc3_wait_timer.sv
// Memory access timer: counts cycles while busy, flags the final one.
// Clears whenever the owning state is left, so no access inherits a count.
import slc3_pkg::*;

module slc3_wait_timer #(
  parameter int MEM_WAIT = MEM_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_busy,
  output logic o_last
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  logic [CW-1:0] r_cnt;

  assign o_last = i_busy && (r_cnt == CW'(MEM_WAIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_busy || o_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/slc3_sequencer.sv
// SLC-3 control FSM: fetch/decode/execute with Moore-decoded datapath controls.
// Define SLC3_SINGLE_STEP_EN to park in PAUSE1/PAUSE2 after every instruction.
import slc3_pkg::*;

module slc3_sequencer #(
  parameter int MEM_WAIT = MEM_WAIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_i,
  input  logic        continue_i,
  input  logic [15:0] ir,
  input  logic        ben,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_pc,
  output logic        ld_ben,
  output logic        ld_cc,
  output logic        ld_reg,
  output logic        ld_led,
  output logic        gate_pc,
  output logic        gate_mdr,
  output logic        gate_alu,
  output logic        gate_marmux,
  output logic [1:0]  pcmux,
  output logic        addr1mux,
  output logic [1:0]  addr2mux,
  output logic        drmux,
  output logic        sr1mux,
  output logic        sr2mux,
  output logic [1:0]  aluk,
  output logic        mem_mem_ena,
  output logic        mem_wr_ena
);

`ifdef SLC3_SINGLE_STEP_EN
  localparam state_t RET = PAUSE1;
`else
  localparam state_t RET = S18;
`endif

  state_t     r_state;
  state_t     w_next;
  logic       w_last;
  logic       w_led;
  logic [3:0] w_op;
  logic       w_unused_ir;

  assign w_op        = ir[15:12];
  assign w_unused_ir = ^{ir[10:6], ir[4:0]};

  slc3_wait_timer #(
    .MEM_WAIT(MEM_WAIT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .i_busy(is_wait(r_state)),
    .o_last(w_last)
  );

`ifdef SLC3_SINGLE_STEP_EN
  assign w_led = 1'b0;
`else
  // LED latches only on the first PAUSE1 cycle
  logic r_led_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led_done <= 1'b0;
    end else begin
      r_led_done <= (r_state == PAUSE1);
    end
  end

  assign w_led = (r_state == PAUSE1) && !r_led_done;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HALTED;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HALTED: if (run_i) w_next = S18;
      S18:    w_next = S33;
      S33:    if (w_last) w_next = S35;
      S35:    w_next = S32;
      S32: begin
        case (w_op)
          OP_ADD:   w_next = S1;
          OP_AND:   w_next = S5;
          OP_NOT:   w_next = S9;
          OP_BR:    w_next = S0;
          OP_JMP:   w_next = S12;
          OP_JSR:   w_next = ir[11] ? S4 : RET;
          OP_LDR:   w_next = S6;
          OP_STR:   w_next = S7;
          OP_PAUSE: w_next = PAUSE1;
          default:  w_next = RET;
        endcase
      end
      S1, S5, S9: w_next = RET;
      S0:     w_next = ben ? S22 : RET;
      S22:    w_next = RET;
      S12:    w_next = RET;
      S4:     w_next = S21;
      S21:    w_next = RET;
      S6:     w_next = S25;
      S25:    if (w_last) w_next = S27;
      S27:    w_next = RET;
      S7:     w_next = S23;
      S23:    w_next = S16;
      S16:    if (w_last) w_next = RET;
      PAUSE1: if (continue_i) w_next = PAUSE2;
      PAUSE2: if (!continue_i) w_next = S18;
      default: w_next = HALTED;
    endcase
  end

  always_comb begin
    ld_mar      = 1'b0;
    ld_mdr      = 1'b0;
    ld_ir       = 1'b0;
    ld_pc       = 1'b0;
    ld_ben      = 1'b0;
    ld_cc       = 1'b0;
    ld_reg      = 1'b0;
    ld_led      = 1'b0;
    gate_pc     = 1'b0;
    gate_mdr    = 1'b0;
    gate_alu    = 1'b0;
    gate_marmux = 1'b0;
    pcmux       = PCMUX_PC1;
    addr1mux    = 1'b0;
    addr2mux    = A2_ZERO;
    drmux       = 1'b0;
    sr1mux      = 1'b0;
    sr2mux      = 1'b0;
    aluk        = ALUK_ADD;
    mem_mem_ena = 1'b0;
    mem_wr_ena  = 1'b0;
    case (r_state)
      S18: begin
        gate_pc = 1'b1;
        ld_mar  = 1'b1;
        ld_pc   = 1'b1;
      end
      S33, S25: begin
        mem_mem_ena = 1'b1;
        ld_mdr      = w_last;
      end
      S35: begin
        gate_mdr = 1'b1;
        ld_ir    = 1'b1;
      end
      S32: ld_ben = 1'b1;
      S1, S5, S9: begin
        sr1mux   = 1'b1;
        sr2mux   = (r_state != S9) && ir[5];
        aluk     = (r_state == S1) ? ALUK_ADD :
                   (r_state == S5) ? ALUK_AND : ALUK_NOT;
        gate_alu = 1'b1;
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
      end
      S22: begin
        addr2mux = A2_OFF9;
        pcmux    = PCMUX_ADDER;
        ld_pc    = 1'b1;
      end
      S12: begin
        sr1mux   = 1'b1;
        addr1mux = 1'b1;
        pcmux    = PCMUX_ADDER;
        ld_pc    = 1'b1;
      end
      S4: begin
        gate_pc = 1'b1;
        drmux   = 1'b1;
        ld_reg  = 1'b1;
      end
      S21: begin
        addr2mux = A2_OFF11;
        pcmux    = PCMUX_ADDER;
        ld_pc    = 1'b1;
      end
      S6, S7: begin
        sr1mux      = 1'b1;
        addr1mux    = 1'b1;
        addr2mux    = A2_OFF6;
        gate_marmux = 1'b1;
        ld_mar      = 1'b1;
      end
      S27: begin
        gate_mdr = 1'b1;
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
      end
      // MDR takes the bus here since the memory enable stays low
      S23: begin
        aluk     = ALUK_PASSA;
        gate_alu = 1'b1;
        ld_mdr   = 1'b1;
      end
      S16: begin
        mem_mem_ena = 1'b1;
        mem_wr_ena  = 1'b1;
      end
      PAUSE1: ld_led = w_led;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_slc3_sequencer.sv
// Bench for slc3_sequencer: per-cycle expected control words built from
// instruction-level sequencing rules, plus a few literal pins.
import slc3_pkg::*;

module tb_slc3_sequencer;

  localparam logic [23:0] LD_MAR   = 24'h800000;
  localparam logic [23:0] LD_MDR   = 24'h400000;
  localparam logic [23:0] LD_IR    = 24'h200000;
  localparam logic [23:0] LD_PC    = 24'h100000;
  localparam logic [23:0] LD_BEN   = 24'h080000;
  localparam logic [23:0] LD_CC    = 24'h040000;
  localparam logic [23:0] LD_REG   = 24'h020000;
  localparam logic [23:0] LD_LED   = 24'h010000;
  localparam logic [23:0] G_PC     = 24'h008000;
  localparam logic [23:0] G_MDR    = 24'h004000;
  localparam logic [23:0] G_ALU    = 24'h002000;
  localparam logic [23:0] G_MARMUX = 24'h001000;
  localparam logic [23:0] PC_ADD   = 24'h000800;
  localparam logic [23:0] A1_SR1   = 24'h000200;
  localparam logic [23:0] A2_OFF6W = 24'h000080;
  localparam logic [23:0] A2_OFF9W = 24'h000100;
  localparam logic [23:0] A2_OF11W = 24'h000180;
  localparam logic [23:0] DR_R7    = 24'h000040;
  localparam logic [23:0] SR1_86   = 24'h000020;
  localparam logic [23:0] SR2_IMM  = 24'h000010;
  localparam logic [23:0] AL_AND   = 24'h000004;
  localparam logic [23:0] AL_NOT   = 24'h000008;
  localparam logic [23:0] AL_PASS  = 24'h00000C;
  localparam logic [23:0] MEM      = 24'h000002;
  localparam logic [23:0] WR       = 24'h000001;

  typedef struct {
    logic        rst;
    logic        run;
    logic        cont;
    logic [15:0] ir;
    logic        ben;
    logic [23:0] exp;
    logic [23:0] msk;
    bit          lit_en;
    logic [23:0] lit;
    string       tag;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_i = 1'b0;
  logic        continue_i = 1'b0;
  logic [15:0] ir = 16'h0;
  logic        ben = 1'b0;
  logic ld_mar, ld_mdr, ld_ir, ld_pc, ld_ben, ld_cc, ld_reg, ld_led;
  logic gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic [1:0] pcmux, addr2mux, aluk;
  logic addr1mux, drmux, sr1mux, sr2mux, mem_mem_ena, mem_wr_ena;
  logic [23:0] w_dut;

  rec_t        q[$];
  logic        m_rst = 1'b0;
  logic        m_run = 1'b0;
  logic        m_cont = 1'b0;
  logic [15:0] m_ir = 16'h0;
  logic        m_ben = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  slc3_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .run_i      (run_i),
    .continue_i (continue_i),
    .ir         (ir),
    .ben        (ben),
    .ld_mar     (ld_mar),
    .ld_mdr     (ld_mdr),
    .ld_ir      (ld_ir),
    .ld_pc      (ld_pc),
    .ld_ben     (ld_ben),
    .ld_cc      (ld_cc),
    .ld_reg     (ld_reg),
    .ld_led     (ld_led),
    .gate_pc    (gate_pc),
    .gate_mdr   (gate_mdr),
    .gate_alu   (gate_alu),
    .gate_marmux(gate_marmux),
    .pcmux      (pcmux),
    .addr1mux   (addr1mux),
    .addr2mux   (addr2mux),
    .drmux      (drmux),
    .sr1mux     (sr1mux),
    .sr2mux     (sr2mux),
    .aluk       (aluk),
    .mem_mem_ena(mem_mem_ena),
    .mem_wr_ena (mem_wr_ena)
  );

  assign w_dut = {ld_mar, ld_mdr, ld_ir, ld_pc, ld_ben, ld_cc, ld_reg,
                  ld_led, gate_pc, gate_mdr, gate_alu, gate_marmux,
                  pcmux, addr1mux, addr2mux, drmux, sr1mux, sr2mux,
                  aluk, mem_mem_ena, mem_wr_ena};

  task automatic put(input logic [23:0] e, input string tag,
                     input logic [23:0] msk = 24'hFFFFFF);
    rec_t r;
    r.rst = m_rst;
    r.run = m_run;
    r.cont = m_cont;
    r.ir = m_ir;
    r.ben = m_ben;
    r.exp = e;
    r.msk = msk;
    r.lit_en = 1'b0;
    r.lit = '0;
    r.tag = tag;
    q.push_back(r);
  endtask

  task automatic pin(input int idx, input logic [23:0] v);
    q[idx].lit_en = 1'b1;
    q[idx].lit = v;
  endtask

  task automatic reads(input string tag);
    for (int k = 0; k < MEM_WAIT_DEF; k++)
      put(MEM | ((k == MEM_WAIT_DEF - 1) ? LD_MDR : 24'h0), tag);
  endtask

  task automatic fetch();
    put(G_PC | LD_MAR | LD_PC, "fetch_pc");
    reads("fetch_rd");
    put(G_MDR | LD_IR, "fetch_ir");
    put(LD_BEN, "decode");
  endtask

  // A pause: entry, optional idle, continue high, then release.
  task automatic pause_seq(input bit led, input bit held);
    if (!held) begin
      m_cont = 1'b0;
      put(led ? LD_LED : 24'h0, "pause_entry");
      put(24'h0, "pause_wait");
      m_cont = 1'b1;
      repeat (5) put(24'h0, "pause_cont");
    end else begin
      m_cont = 1'b1;
      put(led ? LD_LED : 24'h0, "pause_entry_held");
      repeat (2) put(24'h0, "pause_held");
    end
    m_cont = 1'b0;
    put(24'h0, "pause_release");
  endtask

  task automatic ret();
`ifdef SLC3_SINGLE_STEP_EN
    pause_seq(1'b0, 1'b0);
`endif
  endtask

  task automatic instr(input logic [15:0] v, input logic b,
                       input bit held = 1'b0);
    logic [23:0] w;
    m_ir = v;
    m_ben = b;
    fetch();
    case (v[15:12])
      4'b0001, 4'b0101: begin
        w = G_ALU | SR1_86 | LD_REG | LD_CC;
        if (v[15:12] == 4'b0101) w = w | AL_AND;
        if (v[5]) w = w | SR2_IMM;
        put(w, "alu");
        ret();
      end
      4'b1001: begin
        put(G_ALU | SR1_86 | LD_REG | LD_CC | AL_NOT, "not", ~SR2_IMM);
        ret();
      end
      4'b0000: begin
        put(24'h0, "br");
        if (b) put(PC_ADD | A2_OFF9W | LD_PC, "br_taken");
        ret();
      end
      4'b1100: begin
        put(SR1_86 | A1_SR1 | PC_ADD | LD_PC, "jmp");
        ret();
      end
      4'b0100: begin
        if (v[11]) begin
          put(G_PC | DR_R7 | LD_REG, "jsr_link");
          put(A2_OF11W | PC_ADD | LD_PC, "jsr_pc");
        end
        ret();
      end
      4'b0110: begin
        put(SR1_86 | A1_SR1 | A2_OFF6W | G_MARMUX | LD_MAR, "ldr_mar");
        reads("ldr_rd");
        put(G_MDR | LD_REG | LD_CC, "ldr_wb");
        ret();
      end
      4'b0111: begin
        put(SR1_86 | A1_SR1 | A2_OFF6W | G_MARMUX | LD_MAR, "str_mar");
        put(AL_PASS | G_ALU | LD_MDR, "str_mdr");
        repeat (MEM_WAIT_DEF) put(MEM | WR, "str_wr");
        ret();
      end
      4'b1101: begin
`ifdef SLC3_SINGLE_STEP_EN
        pause_seq(1'b0, held);
`else
        pause_seq(1'b1, held);
`endif
      end
      default: ret();
    endcase
  endtask

  initial begin
    int idx;
    int e;
    e = MEM_WAIT_DEF + 3;

    m_rst = 1'b1;
    put(24'h0, "reset");
    m_rst = 1'b0;
    put(24'h0, "halted_idle");
    m_run = 1'b1;
    put(24'h0, "halted_run");
    m_run = 1'b0;

    idx = q.size();
    instr(16'h1242, 1'b0);
    pin(idx, 24'h908000);
    pin(idx + 2, 24'h400002);
    pin(idx + 3, 24'h204000);
    pin(idx + e, 24'h062020);

    instr(16'h5025, 1'b0);
    instr(16'h927F, 1'b0);
    instr(16'h0E05, 1'b0);
    idx = q.size();
    instr(16'h0E05, 1'b1);
    pin(idx + e, 24'h000000);
    pin(idx + e + 1, 24'h100900);
    instr(16'hC1C0, 1'b0);
    instr(16'h4803, 1'b0);
    instr(16'h4080, 1'b0);
    instr(16'h6442, 1'b0);
    idx = q.size();
    instr(16'h7442, 1'b0);
    pin(idx + e, 24'h8012A0);
    pin(idx + e + 1, 24'h40200C);
    pin(idx + e + 2, 24'h000003);
    pin(idx + e + 3, 24'h000003);
    idx = q.size();
    instr(16'hD0FF, 1'b0);
`ifndef SLC3_SINGLE_STEP_EN
    pin(idx + e, 24'h010000);
`endif
    instr(16'hD0FF, 1'b0, 1'b1);
    m_run = 1'b1;
    instr(16'h8000, 1'b0);
    m_run = 1'b0;

    // reset in the final read cycle of a fetch
    put(G_PC | LD_MAR | LD_PC, "rst_fetch_pc");
    put(MEM, "rst_rd1");
    m_rst = 1'b1;
    put(MEM | ((MEM_WAIT_DEF == 2) ? LD_MDR : 24'h0), "rst_rd2");
    m_rst = 1'b0;
    idx = q.size();
    put(24'h0, "rst_halted");
    pin(idx, 24'h000000);
    m_run = 1'b1;
    put(24'h0, "rst_run");
    m_run = 1'b0;
    instr(16'h1242, 1'b0);

    // reset during the first write cycle of a store
    m_ir = 16'h7442;
    fetch();
    put(SR1_86 | A1_SR1 | A2_OFF6W | G_MARMUX | LD_MAR, "abort_mar");
    put(AL_PASS | G_ALU | LD_MDR, "abort_mdr");
    m_rst = 1'b1;
    put(MEM | WR, "abort_wr");
    m_rst = 1'b0;
    repeat (3) put(24'h0, "abort_halted");

    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      reset = q[i].rst;
      run_i = q[i].run;
      continue_i = q[i].cont;
      ir = q[i].ir;
      ben = q[i].ben;
      @(negedge clk);
      total++;
      if ((w_dut & q[i].msk) !== (q[i].exp & q[i].msk)) begin
        bad++;
        $display("FAIL cyc%0d %s got=%h want=%h",
                 i, q[i].tag, w_dut, q[i].exp);
      end
      if (q[i].lit_en) begin
        total++;
        if (w_dut !== q[i].lit) begin
          bad++;
          $display("FAIL cyc%0d lit_%s got=%h want=%h",
                   i, q[i].tag, w_dut, q[i].lit);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
